// File: rtl/golden_nonce_tx.sv
// Buffers golden nonces in a small FIFO and sends each one LSB byte first over an 8N1 UART.
// Define GNTX_SYNC_EN to put a 0xAA sync byte in front of every nonce.
module golden_nonce_tx #(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          hash_clk,
    input  logic                          rst_n,
    input  logic [31:0]                   golden_nonce,
    input  logic                          golden_nonce_match,
    input  logic                          clr_ovf,
    output logic                          txd,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       SYNC_BYTE = 8'hAA;
`ifdef GNTX_SYNC_EN
    localparam bit         SYNC_EN   = 1'b1;
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam bit         SYNC_EN   = 1'b0;
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        shreg_q, shreg_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [31:0]        mem [FIFO_DEPTH];

    logic               full, pop, push, drop;
    logic [31:0]        head;
    logic [7:0]         cur_byte;
    logic [2:0]         next_bit;

    always_comb begin
        full       = (count_q == FULL_CNT);
        pop        = (state_q == IDLE) && (count_q != '0);
        push       = golden_nonce_match && (!full || pop);
        drop       = golden_nonce_match && !push;
        head       = mem[rd_ptr_q];
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = drop | (overflow_q & ~clr_ovf);

        cur_byte   = (SYNC_EN && byte_cnt_q == 3'd0) ? SYNC_BYTE : shreg_q[7:0];
        next_bit   = bit_cnt_q + 3'd1;

        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = START;
                    shreg_d    = head;
                    byte_cnt_d = 3'd0;
                    baud_cnt_d = BAUD_MAX;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (baud_cnt_q == '0) begin
                    state_d    = DATA;
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = BAUD_MAX;
                    txd_d      = cur_byte[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_MAX;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = next_bit;
                        txd_d     = cur_byte[next_bit];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_MAX;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end else begin
                        state_d    = START;
                        txd_d      = 1'b0;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        // The sync byte is not held in the shift register, so no shift after it.
                        if (!(SYNC_EN && byte_cnt_q == 3'd0)) begin
                            shreg_d = shreg_q >> 8;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= golden_nonce;
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Self-checking bench for golden_nonce_tx: a queue-plus-frame-timer model predicts txd/busy/overflow/fifo_count every cycle.
module tb_golden_nonce_tx;

    localparam int B = 4;
    localparam int D = 4;
`ifdef GNTX_SYNC_EN
    localparam int NBYTES = 5;
    localparam int NOFF   = 1;
`else
    localparam int NBYTES = 4;
    localparam int NOFF   = 0;
`endif
    localparam int FRAME_CYC = NBYTES * 10 * B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] nonce;
    logic        match;
    logic        clr;
    logic        txd;
    logic        busy;
    logic        ovf;
    logic [2:0]  fcount;

    always #5 clk = ~clk;

    golden_nonce_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
        .hash_clk           (clk),
        .rst_n              (rst_n),
        .golden_nonce       (nonce),
        .golden_nonce_match (match),
        .clr_ovf            (clr),
        .txd                (txd),
        .busy               (busy),
        .overflow           (ovf),
        .fifo_count         (fcount)
    );

    int          vectors = 0;
    int          miscompares = 0;

    // Reference model: accepted nonces waiting, cycles of busy left in the current frame, sticky flag.
    logic [31:0] mq[$];
    int          tx_timer = 0;
    bit          m_ovf = 1'b0;
    bit          fbits[NBYTES*10];

    logic        rec[FRAME_CYC+10];
    logic [7:0]  db[NBYTES];
    logic [31:0] stops;
    int          busy_cnt;
    int          peak;
    int          bad;
    int          k;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic buildFrame(input logic [31:0] n);
        logic [7:0] b;
        for (int j = 0; j < NBYTES; j++) begin
            if (j < NOFF) b = 8'hAA;
            else          b = n[8*(j-NOFF) +: 8];
            fbits[j*10] = 1'b0;
            for (int i = 0; i < 8; i++) fbits[j*10+1+i] = b[i];
            fbits[j*10+9] = 1'b1;
        end
    endtask

    task automatic modelEdge(input bit m, input logic [31:0] n, input bit c);
        bit p, q;
        p = (tx_timer == 0) && (mq.size() > 0);
        q = m && ((mq.size() < D) || p);
        if (p) begin
            buildFrame(mq.pop_front());
            tx_timer = FRAME_CYC;
        end else if (tx_timer > 0) begin
            tx_timer--;
        end
        if (q) mq.push_back(n);
        if (m && !q)   m_ovf = 1'b1;
        else if (c)    m_ovf = 1'b0;
    endtask

    task automatic checkOutput();
        logic exp_txd;
        exp_txd = (tx_timer > 0) ? fbits[(FRAME_CYC - tx_timer) / B] : 1'b1;
        checkVal("txd", 32'(txd), 32'(exp_txd));
        checkVal("busy", 32'(busy), 32'(tx_timer > 0));
        checkVal("overflow", 32'(ovf), 32'(m_ovf));
        checkVal("fifo_count", 32'(fcount), 32'(mq.size()));
    endtask

    task automatic applyStimulus(input bit m, input logic [31:0] n, input bit c);
        match = m;
        nonce = m ? n : $urandom;
        clr   = c;
        @(posedge clk);
        modelEdge(m, n, c);
        #1;
        checkOutput();
    endtask

    task automatic drainAll();
        int n = 0;
        while (!(busy === 1'b0 && fcount === 3'd0 && tx_timer == 0 && mq.size() == 0)
               && n < 8 * (FRAME_CYC + 1)) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            n++;
        end
        checkVal("drain_timeout", 32'(busy === 1'b0 && fcount === 3'd0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        match = 1'b0;
        clr   = 1'b0;
        nonce = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_txd", 32'(txd), 32'd1);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_ovf", 32'(ovf), 32'd0);
        checkVal("rst_count", 32'(fcount), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);

        // Single nonce, recorded and decoded independently of the model
        applyStimulus(1'b1, 32'h12345678, 1'b0);
        checkVal("cap_count", 32'(fcount), 32'd1);
        busy_cnt = 0;
        for (int c = 0; c < FRAME_CYC + 10; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            rec[c] = txd;
            if (busy === 1'b1) busy_cnt++;
        end
        checkVal("start_bit", 32'(rec[0]), 32'd0);
        stops = 32'h0;
        for (int j = 0; j < NBYTES; j++) begin
            for (int i = 0; i < 8; i++) db[j][i] = rec[j*10*B + (1+i)*B + B/2];
            stops[j] = rec[j*10*B + 9*B + B/2];
        end
        checkVal("decoded_nonce", {db[NOFF+3], db[NOFF+2], db[NOFF+1], db[NOFF]}, 32'h12345678);
`ifdef GNTX_SYNC_EN
        checkVal("sync_byte", 32'(db[0]), 32'hAA);
`endif
        checkVal("stop_bits", stops, 32'((1 << NBYTES) - 1));
        checkVal("busy_cycles", 32'(busy_cnt), 32'(FRAME_CYC));
        checkVal("post_txd", 32'(txd), 32'd1);
        checkVal("post_count", 32'(fcount), 32'd0);

        // Burst of three consecutive strobes
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0);
            if (int'(fcount) > peak) peak = int'(fcount);
        end
        checkVal("burst_peak", 32'(peak), 32'd2);
        drainAll();

        // Overflow: six strobes, then clear racing a drop, then a plain clear
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom, 1'b0);
        checkVal("ovf_set", 32'(ovf), 32'd1);
        checkVal("ovf_count", 32'(fcount), 32'(D));
        applyStimulus(1'b1, $urandom, 1'b1);
        checkVal("ovf_clr_vs_drop", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("ovf_cleared", 32'(ovf), 32'd0);

        // Full FIFO, strobe lands on the idle cycle where the pop happens
        k = 0;
        while (!(busy === 1'b0 && fcount === 3'(D)) && k < FRAME_CYC + 10) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            k++;
        end
        checkVal("full_idle_reached", 32'(busy === 1'b0 && fcount === 3'(D)), 32'd1);
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
        checkVal("full_pop_count", 32'(fcount), 32'(D));
        checkVal("full_pop_ovf", 32'(ovf), 32'd0);
        checkVal("full_pop_busy", 32'(busy), 32'd1);
        drainAll();

        // Asynchronous reset in the middle of the second byte
        applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b0);
        repeat (13 * B) applyStimulus(1'b0, 32'h0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkVal("midrst_txd", 32'(txd), 32'd1);
        checkVal("midrst_busy", 32'(busy), 32'd0);
        checkVal("midrst_count", 32'(fcount), 32'd0);
        checkVal("midrst_ovf", 32'(ovf), 32'd0);
        mq.delete();
        tx_timer = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            if (busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        checkVal("post_rst_quiet", 32'(bad), 32'd0);
        applyStimulus(1'b1, 32'hA5C30F1E, 1'b0);
        drainAll();

        // Randomised traffic with occasional back-to-back bursts and clears
        repeat (2500) begin
            if ($urandom_range(0, 249) == 0) begin
                repeat (6) applyStimulus(1'b1, $urandom, $urandom_range(0, 1) == 1);
            end else begin
                applyStimulus($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 79) == 0);
            end
        end
        drainAll();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/golden_nonce_tx.md
# golden_nonce_tx

Downstream consumer of the hashcore result path: captures each 32-bit golden nonce presented with its one-cycle match strobe, buffers it in a small FIFO, and serialises it to the host over an 8N1 UART line. Sits between the hashcore instances and the board TX pin. Decouples nonce discovery from the slow serial link, so back-to-back matches are not lost while a previous nonce is still being sent.

## Interface
- `BAUD_DIV`, 104: `hash_clk` cycles per UART bit. Legal range is 2 to 65535.
- `FIFO_DEPTH`, 4: nonce entries buffered. Must be a power of 2, at least 2.
- `hash_clk`  in  1  sole clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `golden_nonce`  in  32  nonce value. Valid only while `golden_nonce_match` is high.
- `golden_nonce_match`  in  1  one-cycle strobe requesting capture of `golden_nonce`.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `txd`  out  1  UART serial output. Idle level is high.
- `busy`  out  1  high while a frame is being shifted out.
- `overflow`  out  1  sticky flag: a nonce was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of entries currently held.

## Operation
- **FIFO.**
  - Circular buffer with wrapping read/write pointers.
  - A push happens on any `golden_nonce_match` cycle when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - A match that arrives while the FIFO is full with no simultaneous pop is dropped; `overflow` is set to 1.
  - Simultaneous push and pop: `fifo_count` is unchanged and both operations complete.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START: when `fifo_count` is not 0. The head entry is popped into a 32-bit shift register, the byte counter is cleared, and `txd` is driven to 0.
  - START → DATA: after `BAUD_DIV` cycles. Data bits go out LSB first.
  - DATA → STOP: after 8 bit periods. `txd` is driven to 1.
  - STOP → START: after `BAUD_DIV` cycles, if bytes remain. The shift register shifts right by 8 bits.
  - STOP → IDLE: after `BAUD_DIV` cycles, when the last byte has been sent.
- **Byte order:** `golden_nonce[7:0]` first, `golden_nonce[31:24]` last, giving 4 bytes per nonce.
- **`busy`:** high in START, DATA and STOP; low in IDLE.
- **Bit-period counter:** width `$clog2(BAUD_DIV)`. Counts `BAUD_DIV-1` down to 0. It reloads on every state or bit transition.
- **`overflow`:** set by a dropped match, cleared by `clr_ovf`. If both occur in the same cycle, set wins.
- **Reset (asynchronous, any time, including mid-frame):**
  - FIFO is emptied and the FSM returns to IDLE.
  - Outputs: `txd`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - A partially sent byte is abandoned and is not resumed after reset.

## Timing
- **Capture:** the strobe high at edge E0 writes the FIFO at E0. `fifo_count` shows the new value after E0.
- **Start of frame:** from an empty, idle block, the pop happens at E1 and `txd` falls after E1. The nonce start bit therefore begins 1 cycle after the capture edge.
- **Frame lengths:**
  - One byte frame is exactly 10 × `BAUD_DIV` cycles.
  - The 4 bytes of one nonce go out back-to-back with no idle gap, 40 × `BAUD_DIV` cycles in total.
- **Between nonces:** exactly 1 IDLE cycle with `txd`=1 and `busy`=0 separates consecutive nonces when the FIFO still holds entries.
- **Strobe rate:** `golden_nonce_match` may be high on consecutive cycles. Each high cycle is an independent capture request.

## Configuration
- `GNTX_SYNC_EN` defined:
  - Each nonce is preceded by a sync byte 0xAA, sent as a normal 8N1 byte.
  - A nonce frame is 5 bytes, 50 × `BAUD_DIV` cycles.
  - The byte counter covers 0 to 4, and the pop still happens on the IDLE → START transition.
- `GNTX_SYNC_EN` undefined: a nonce frame is the 4 nonce bytes only, with no sync byte.

## Test plan
- **Single nonce:** `BAUD_DIV`=4, strobe with 0x12345678. Expect `txd` to show bytes 0x78, 0x56, 0x34, 0x12 LSB-first with correct start and stop bits, `busy` high for 160 cycles, then `txd`=1 and `fifo_count`=0.
- **Burst:** 3 strobes on consecutive cycles (0x1, 0x2, 0x3). Expect `fifo_count` to peak at 2 (the first entry is popped at E1), all three nonces sent in order, and a 1-cycle idle gap between frames.
- **Overflow:** `FIFO_DEPTH`=4, 6 strobes on consecutive cycles. Expect 5 nonces accepted (the first is popped early), the 6th dropped, and `overflow`=1 until `clr_ovf` is pulsed. `clr_ovf` coinciding with a drop leaves `overflow`=1.
- **Full with simultaneous pop:** FIFO full and the FSM entering START in the same cycle as a strobe. Expect the push to be accepted, `fifo_count` unchanged, and `overflow`=0.
- **Reset mid-frame:** assert `rst_n`=0 during the second byte. Expect immediately `txd`=1, `busy`=0, `fifo_count`=0, and no output after release until a new strobe arrives.
- **`GNTX_SYNC_EN` defined:** strobe 0xDEADBEEF. Expect the byte sequence 0xAA, 0xEF, 0xBE, 0xAD, 0xDE and 50 × `BAUD_DIV` busy cycles.
